pipe_scoreboard: RTL and testbench
==================================

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter STAGES, default 4, meaning number of tracked in-flight slots between decode and writeback (min 2).
REQ-002 SHALL have parameter REG_ADDR_W, default 5, meaning register-address width.
REQ-003 SHALL have parameter FLUSH_DEPTH, default 1, meaning number of youngest slots killed by flush (1..STAGES).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rstb  in  1  synchronous, active-low reset.
- id_valid  in  1  decode holds an instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source addresses.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_ADDR_W  destination.
- id_rd_wr  in  1  instruction writes rd.
- id_is_load  in  1  result available only at slot 1 or later.
- hold  in  1  external pipeline freeze (memory wait).
- flush  in  1  kill younger instructions (branch taken).
- id_issue  out  1  instruction accepted this cycle.
- stall  out  1  hazard or hold blocks decode.
- wb_valid, wb_rd_wr  out  1  instruction retiring from last slot.
- wb_rd  out  REG_ADDR_W  retiring destination.
- fwd_sel_rs1, fwd_sel_rs2  out  STAGES  one-hot forward source slot, 0 = register file.
- inflight  out  clog2(STAGES+1)  count of valid slots.

Function
REQ-005 SHALL hold STAGES slots {valid, rd, wr, load}; slot 0 youngest, slot STAGES-1 oldest.
REQ-006 SHALL treat a source as matching slot i when slot valid, wr=1, rd==source, source used, source!=0.
REQ-007 SHALL never flag hazards on register 0.
REQ-008 SHALL compute hazard, id_issue, stall, fwd_sel combinationally in the same cycle from current slots and id inputs.
REQ-009 SHALL drive id_issue = id_valid & !hazard & !hold & !flush.
REQ-010 SHALL drive stall = id_valid & (hazard | hold).
REQ-011 SHALL, on each edge with hold=0, shift slot i-1 into slot i and load slot 0 with the issuing instruction when id_issue=1, else a bubble (valid=0).
REQ-012 SHALL freeze all slots on each edge with hold=1 and flush=0.
REQ-013 SHALL, on flush=1, invalidate the slots that would become slots 0..FLUSH_DEPTH-1 after the edge; flush with hold=1 invalidates current slots 0..FLUSH_DEPTH-2 and holds the rest; FLUSH_DEPTH=1 with hold then kills only the issue.
REQ-014 SHALL drive wb_valid/wb_rd/wb_rd_wr from slot STAGES-1, combinationally; wb_valid forced 0 while hold=1.
REQ-015 SHALL drive inflight as popcount of slot valid bits.
REQ-016 SHALL give latency STAGES edges from id_issue to wb_valid with no hold.
REQ-017 SHALL, on multiple matches, select the youngest matching slot (lowest index) for forwarding.

Reset
REQ-018 SHALL, when rstb=0 at a rising edge, clear all slot valid bits; rd/wr/load fields don't-care.
REQ-019 SHALL, during and after reset, give id_issue=id_valid (hold=0), stall=0, wb_valid=0, fwd_sel=0, inflight=0.
REQ-020 SHALL let reset override hold and flush; reset mid-operation discards all in-flight entries.

Configuration
REQ-021 SHALL honour macro PHILV_FWD_EN.
REQ-022 SHALL, with PHILV_FWD_EN defined, raise hazard only for a match on slot 0 whose load=1; other matches produce fwd_sel one-hot for the youngest match.
REQ-023 SHALL, without PHILV_FWD_EN, raise hazard on any match and tie fwd_sel_rs1/rs2 to 0.

Verification
REQ-024 SHALL cover reset: rstb=0 one edge with slots full -> inflight=0, wb_valid=0, stall=0 next cycle.
REQ-025 SHALL cover RAW: issue rd=5 wr=1, next id_rs1=5 used -> no FWD: stall=1 for 4 cycles, then id_issue; FWD: fwd_sel_rs1=0001, no stall.
REQ-026 SHALL cover load-use (FWD): load rd=7, next rs2=7 -> stall 1 cycle, then fwd_sel_rs2=0010.
REQ-027 SHALL cover x0: issue rd=0 wr=1, next rs1=0 -> stall=0, fwd_sel=0.
REQ-028 SHALL cover hold/flush: 3 issued, hold 2 cycles -> inflight constant 3, wb_valid=0; then flush (FLUSH_DEPTH=1) -> inflight drops by 1 vs unflushed, issue blocked that cycle.
REQ-029 SHALL cover throughput: independent instructions every cycle -> id_issue=1 continuously, inflight saturates at 4, wb_valid=1 from cycle 4.

Source files
------------

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-order pipeline scoreboard: RAW hazard detect, forward select, hold/flush tracking
//
// Optional feature macro: PHILV_FWD_EN
//   defined   : operands are forwarded from any in-flight slot; only load-use on slot 0 stalls
//   undefined : no forwarding; any in-flight producer of a used source stalls decode
//
// Ports
//   clk                      rising-edge clock
//   rstb                     synchronous active-low reset (clears slot valid bits)
//   id_valid                 decode holds an instruction
//   id_rs1, id_rs2           source register addresses
//   id_rs1_used, id_rs2_used source actually read
//   id_rd, id_rd_wr          destination and write enable
//   id_is_load               result not available until slot 1
//   hold                     freeze the pipeline (memory wait)
//   flush                    kill younger instructions (taken branch)
//   id_issue                 instruction accepted this cycle
//   stall                    decode blocked by hazard or hold
//   wb_valid, wb_rd, wb_rd_wr instruction retiring from the oldest slot
//   fwd_sel_rs1, fwd_sel_rs2 one-hot forward source slot, 0 = register file
//   inflight                 number of valid slots
`timescale 1ns/1ps
module pipe_scoreboard #(
   parameter int STAGES      = 4,
   parameter int REG_ADDR_W  = 5,
   parameter int FLUSH_DEPTH = 1
) (
   input  logic                          clk,
   input  logic                          rstb,
   input  logic                          id_valid,
   input  logic [REG_ADDR_W-1:0]         id_rs1,
   input  logic [REG_ADDR_W-1:0]         id_rs2,
   input  logic                          id_rs1_used,
   input  logic                          id_rs2_used,
   input  logic [REG_ADDR_W-1:0]         id_rd,
   input  logic                          id_rd_wr,
   input  logic                          id_is_load,
   input  logic                          hold,
   input  logic                          flush,
   output logic                          id_issue,
   output logic                          stall,
   output logic                          wb_valid,
   output logic                          wb_rd_wr,
   output logic [REG_ADDR_W-1:0]         wb_rd,
   output logic [STAGES-1:0]             fwd_sel_rs1,
   output logic [STAGES-1:0]             fwd_sel_rs2,
   output logic [$clog2(STAGES+1)-1:0]   inflight
);

   localparam int CNT_W = $clog2(STAGES+1);

   // slot 0 is the youngest, slot STAGES-1 the oldest
   logic [STAGES-1:0]     valid_q, valid_d;
   logic [STAGES-1:0]     wr_q,    wr_d;
   logic [STAGES-1:0]     load_q,  load_d;
   logic [REG_ADDR_W-1:0] rd_q [STAGES];
   logic [REG_ADDR_W-1:0] rd_d [STAGES];

   logic [STAGES-1:0]     match_rs1, match_rs2;
   logic                  hazard;

   // a source matches a slot only if it is really read and is not x0
   always_comb begin
      match_rs1 = '0;
      match_rs2 = '0;
      for (int i = 0; i < STAGES; i++) begin
         match_rs1[i] = valid_q[i] & wr_q[i] & id_rs1_used & (id_rs1 != '0) & (rd_q[i] == id_rs1);
         match_rs2[i] = valid_q[i] & wr_q[i] & id_rs2_used & (id_rs2 != '0) & (rd_q[i] == id_rs2);
      end
   end

`ifdef PHILV_FWD_EN
   // forwarding covers everything except a load still in slot 0;
   // the lowest set bit picks the youngest producer
   always_comb begin
      fwd_sel_rs1 = '0;
      fwd_sel_rs2 = '0;
      for (int i = STAGES-1; i >= 0; i--) begin
         if (match_rs1[i]) fwd_sel_rs1 = STAGES'(1) << i;
         if (match_rs2[i]) fwd_sel_rs2 = STAGES'(1) << i;
      end
      hazard = (match_rs1[0] | match_rs2[0]) & load_q[0];
   end
`else
   always_comb begin
      fwd_sel_rs1 = '0;
      fwd_sel_rs2 = '0;
      hazard      = (|match_rs1) | (|match_rs2);
   end
`endif

   assign id_issue = id_valid & ~hazard & ~hold & ~flush;
   assign stall    = id_valid & (hazard | hold);

   // a frozen pipeline must not report retirement, the entry stays in the last slot
   assign wb_valid = valid_q[STAGES-1] & ~hold;
   assign wb_rd    = rd_q[STAGES-1];
   assign wb_rd_wr = wr_q[STAGES-1];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < STAGES; i++) begin
         inflight = inflight + CNT_W'(valid_q[i]);
      end
   end

   always_comb begin
      valid_d = valid_q;
      wr_d    = wr_q;
      load_d  = load_q;
      rd_d    = rd_q;
      if (!hold) begin
         for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            wr_d[i]    = wr_q[i-1];
            load_d[i]  = load_q[i-1];
            rd_d[i]    = rd_q[i-1];
         end
         valid_d[0] = id_issue;
         wr_d[0]    = id_rd_wr;
         load_d[0]  = id_is_load;
         rd_d[0]    = id_rd;
         // flush kills the slots that become the youngest FLUSH_DEPTH after this edge
         if (flush) begin
            for (int i = 0; i < FLUSH_DEPTH; i++) begin
               valid_d[i] = 1'b0;
            end
         end
      end else if (flush) begin
         // no shift: the blocked issue already counts as one killed slot
         for (int i = 0; i < FLUSH_DEPTH-1; i++) begin
            valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
      wr_q   <= wr_d;
      load_q <= load_d;
      rd_q   <= rd_d;
   end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - directed self-checking bench for pipe_scoreboard
`timescale 1ns/1ps
module tb_pipe_scoreboard;

   logic       clk;
   logic       rstb;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_rs1_used, id_rs2_used, id_rd_wr, id_is_load;
   logic       hold, flush;
   logic       id_issue, stall, wb_valid, wb_rd_wr;
   logic [4:0] wb_rd;
   logic [3:0] fwd_sel_rs1, fwd_sel_rs2;
   logic [2:0] inflight;

   int vectors = 0;
   int miscompares = 0;

   pipe_scoreboard dut (
      .clk(clk), .rstb(rstb), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
      .hold(hold), .flush(flush),
      .id_issue(id_issue), .stall(stall),
      .wb_valid(wb_valid), .wb_rd_wr(wb_rd_wr), .wb_rd(wb_rd),
      .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
      .inflight(inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // inputs change 1ns after the edge, outputs are sampled 1ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = 0; id_rd_wr = 0; id_is_load = 0; hold = 0; flush = 0;
   endtask

   task automatic drive(input logic [4:0] rd, input logic ld,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
      id_valid = 1; id_rd = rd; id_rd_wr = 1; id_is_load = ld;
      id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
   endtask

   initial begin
      idle();
      rstb = 0;
      tick();
      tick();
      rstb = 1;
      #1;
      // reset state
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_wb_valid", 32'(wb_valid), 0);
      chk("rst_stall",    32'(stall), 0);
      chk("rst_fwd1",     32'(fwd_sel_rs1), 0);
      drive(5'd9, 0, 5'd0, 0, 5'd0, 0);
      #1;
      chk("rst_issue", 32'(id_issue), 1);
      idle();

      // RAW on rs1 against rd=5
      drive(5'd5, 0, 5'd0, 0, 5'd0, 0);
      #1;
      chk("raw_first_issue", 32'(id_issue), 1);
      tick();
      drive(5'd6, 0, 5'd5, 1, 5'd0, 0);
      #1;
`ifdef PHILV_FWD_EN
      chk("raw_fwd_sel", 32'(fwd_sel_rs1), 32'h1);
      chk("raw_fwd_stall", 32'(stall), 0);
      chk("raw_fwd_issue", 32'(id_issue), 1);
`else
      for (int k = 0; k < 4; k++) begin
         chk("raw_stall", 32'(stall), 1);
         chk("raw_blocked", 32'(id_issue), 0);
         chk("raw_fwd_zero", 32'(fwd_sel_rs1), 0);
         if (k == 3) begin
            chk("raw_wb_valid", 32'(wb_valid), 1);
            chk("raw_wb_rd", 32'(wb_rd), 5);
         end
         tick();
      end
      chk("raw_release_stall", 32'(stall), 0);
      chk("raw_release_issue", 32'(id_issue), 1);
`endif
      tick();
      idle();
      repeat (4) tick();
      chk("raw_drained", 32'(inflight), 0);

      // load-use on rs2 against a load to r7
      drive(5'd7, 1, 5'd0, 0, 5'd0, 0);
      tick();
      drive(5'd8, 0, 5'd0, 0, 5'd7, 1);
      #1;
      chk("lu_stall0", 32'(stall), 1);
      chk("lu_blocked0", 32'(id_issue), 0);
      tick();
`ifdef PHILV_FWD_EN
      chk("lu_stall1", 32'(stall), 0);
      chk("lu_fwd_sel", 32'(fwd_sel_rs2), 32'h2);
      chk("lu_issue1", 32'(id_issue), 1);
`else
      chk("lu_stall1", 32'(stall), 1);
      chk("lu_fwd_sel", 32'(fwd_sel_rs2), 0);
`endif
      idle();
      repeat (5) tick();
      chk("lu_drained", 32'(inflight), 0);

      // x0 is never a hazard
      drive(5'd0, 0, 5'd0, 0, 5'd0, 0);
      tick();
      drive(5'd3, 0, 5'd0, 1, 5'd0, 1);
      #1;
      chk("x0_inflight", 32'(inflight), 1);
      chk("x0_stall", 32'(stall), 0);
      chk("x0_fwd1", 32'(fwd_sel_rs1), 0);
      chk("x0_issue", 32'(id_issue), 1);
      idle();
      repeat (4) tick();

      // hold / flush
      for (int k = 1; k <= 3; k++) begin
         drive(5'(k), 0, 5'd0, 0, 5'd0, 0);
         tick();
      end
      drive(5'd4, 0, 5'd0, 0, 5'd0, 0);
      hold = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("hold_inflight", 32'(inflight), 3);
         chk("hold_wb_valid", 32'(wb_valid), 0);
         chk("hold_stall", 32'(stall), 1);
         chk("hold_issue", 32'(id_issue), 0);
         tick();
      end
      chk("hold_after", 32'(inflight), 3);
      hold = 0;
      flush = 1;
      #1;
      chk("flush_issue", 32'(id_issue), 0);
      tick();
      flush = 0;
      #1;
      chk("flush_inflight", 32'(inflight), 3);
      chk("flush_wb_valid", 32'(wb_valid), 1);
      chk("flush_wb_rd", 32'(wb_rd), 1);
      hold = 1;
      flush = 1;
      #1;
      chk("holdflush_wb_valid", 32'(wb_valid), 0);
      tick();
      chk("holdflush_inflight", 32'(inflight), 3);
      idle();
      repeat (4) tick();
      chk("hf_drained", 32'(inflight), 0);

      // back-to-back independent instructions
      for (int k = 0; k < 8; k++) begin
         drive(5'(10 + k), 0, 5'd0, 0, 5'd0, 0);
         #1;
         chk("tp_issue", 32'(id_issue), 1);
         chk("tp_inflight", 32'(inflight), (k < 4) ? k : 4);
         chk("tp_wb_valid", 32'(wb_valid), (k >= 4) ? 1 : 0);
         if (k >= 4) chk("tp_wb_rd", 32'(wb_rd), 32'(10 + k - 4));
         tick();
      end

      // reset with every slot full, overriding hold
      idle();
      hold = 1;
      rstb = 0;
      tick();
      rstb = 1;
      hold = 0;
      #1;
      chk("rst2_inflight", 32'(inflight), 0);
      chk("rst2_wb_valid", 32'(wb_valid), 0);
      chk("rst2_stall", 32'(stall), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
